// File: rtl/yurut_pkg.sv
// Shared types for the multi-cycle execute controller: FSM state encoding and
// execution-unit select codes.
package yurut_pkg;

    typedef enum logic [1:0] {
        BOSTA     = 2'd0,
        CALISIYOR = 2'd1,
        YAZ       = 2'd2
    } durum_t;

    typedef enum logic [1:0] {
        BIRIM_AMB      = 2'b00,
        BIRIM_YZ       = 2'b01,
        BIRIM_KRIPTO   = 2'b10,
        BIRIM_AYRILMIS = 2'b11
    } birim_t;

    localparam int HEDEF_GENISLIGI = 5;

    function automatic logic birim_gecerli(input logic [1:0] sec);
        return sec != BIRIM_AYRILMIS;
    endfunction

endpackage

// File: rtl/yurut_denetleyici.sv
// Execute-stage controller: launches one multi-cycle unit operation, waits for
// its result with a timeout, and presents the result for one write-back cycle.
module yurut_denetleyici
    import yurut_pkg::*;
#(
    parameter int ZAMAN_ASIMI    = 64,
    parameter int VERI_GENISLIGI = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       durdur_i,
    input  logic                       bosalt_i,
    input  logic                       istek_gecerli_i,
    input  logic [1:0]                 birim_sec_i,
    input  logic [HEDEF_GENISLIGI-1:0] hedef_yazmaci_i,
    output logic                       amb_baslat_o,
    output logic                       yz_baslat_o,
    output logic                       kripto_baslat_o,
    input  logic                       amb_hazir_i,
    input  logic                       yz_hazir_i,
    input  logic                       kripto_hazir_i,
    input  logic [VERI_GENISLIGI-1:0]  amb_sonuc_i,
    input  logic [VERI_GENISLIGI-1:0]  yz_sonuc_i,
    input  logic [VERI_GENISLIGI-1:0]  kripto_sonuc_i,
    output logic                       yurut_stall_o,
    output logic                       sonuc_gecerli_o,
    output logic [VERI_GENISLIGI-1:0]  sonuc_o,
    output logic [HEDEF_GENISLIGI-1:0] hedef_yazmaci_o,
    output logic                       zaman_asimi_o
);

    localparam int SAYAC_GENISLIGI = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SAYAC_GENISLIGI-1:0] SAYAC_SON = SAYAC_GENISLIGI'(ZAMAN_ASIMI - 1);

    durum_t                       durum_q, durum_d;
    birim_t                       birim_q, birim_d;
    logic [HEDEF_GENISLIGI-1:0]   hedef_q, hedef_d;
    logic [SAYAC_GENISLIGI-1:0]   sayac_q, sayac_d;
    logic                         baslat_yapildi_q, baslat_yapildi_d;
    logic [VERI_GENISLIGI-1:0]    sonuc_q, sonuc_d;
    logic [HEDEF_GENISLIGI-1:0]   hedef_cikis_q, hedef_cikis_d;
    logic                         zaman_asimi_q, zaman_asimi_d;

    logic                         kabul;
    logic                         calis_adim;
    logic                         baslat_aktif;
    logic                         yakala;
    logic                         zaman_doldu;
    logic                         hazir_sec;
    logic [VERI_GENISLIGI-1:0]    sonuc_sec;

    // Gating with rst_i keeps the combinational stall low while reset is held.
    assign kabul = rst_i && (durum_q == BOSTA) && istek_gecerli_i && !durdur_i
                   && !bosalt_i && birim_gecerli(birim_sec_i);

    assign calis_adim   = (durum_q == CALISIYOR) && !durdur_i && !bosalt_i;
    assign baslat_aktif = calis_adim && !baslat_yapildi_q;
    assign yakala       = calis_adim && baslat_yapildi_q && hazir_sec;
    assign zaman_doldu  = calis_adim && !yakala && (sayac_q == SAYAC_SON);

    always_comb begin
        hazir_sec = 1'b0;
        sonuc_sec = '0;
        case (birim_q)
            BIRIM_AMB: begin
                hazir_sec = amb_hazir_i;
                sonuc_sec = amb_sonuc_i;
            end
            BIRIM_YZ: begin
                hazir_sec = yz_hazir_i;
                sonuc_sec = yz_sonuc_i;
            end
            BIRIM_KRIPTO: begin
                hazir_sec = kripto_hazir_i;
                sonuc_sec = kripto_sonuc_i;
            end
            default: begin
                hazir_sec = 1'b0;
                sonuc_sec = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    always_comb begin
        durum_d = durum_q;
        if (bosalt_i) begin
            durum_d = BOSTA;
        end else if (!durdur_i) begin
            case (durum_q)
                BOSTA: begin
                    if (kabul) durum_d = CALISIYOR;
                end
                CALISIYOR: begin
                    if (yakala)           durum_d = YAZ;
                    else if (zaman_doldu) durum_d = BOSTA;
                end
                YAZ:     durum_d = BOSTA;
                default: durum_d = BOSTA;
            endcase
        end
    end

    always_comb begin
        yurut_stall_o   = kabul || (durum_q == CALISIYOR);
        amb_baslat_o    = baslat_aktif && (birim_q == BIRIM_AMB);
        yz_baslat_o     = baslat_aktif && (birim_q == BIRIM_YZ);
        kripto_baslat_o = baslat_aktif && (birim_q == BIRIM_KRIPTO);
        sonuc_gecerli_o = (durum_q == YAZ) && !bosalt_i;
        zaman_asimi_o   = zaman_asimi_q && !bosalt_i;
    end

    assign sonuc_o         = sonuc_q;
    assign hedef_yazmaci_o = hedef_cikis_q;

    // Frozen cycles leave every _d equal to its _q; the timeout flag is the
    // exception, it is rebuilt every edge so the pulse never stretches.
    always_comb begin
        birim_d          = birim_q;
        hedef_d          = hedef_q;
        sayac_d          = sayac_q;
        baslat_yapildi_d = baslat_yapildi_q;
        sonuc_d          = sonuc_q;
        hedef_cikis_d    = hedef_cikis_q;
        zaman_asimi_d    = zaman_doldu;

        if (bosalt_i) begin
            sayac_d          = '0;
            baslat_yapildi_d = 1'b0;
        end else begin
            if (kabul) begin
                birim_d          = birim_t'(birim_sec_i);
                hedef_d          = hedef_yazmaci_i;
                sayac_d          = '0;
                baslat_yapildi_d = 1'b0;
            end
            if (calis_adim) begin
                sayac_d = sayac_q + SAYAC_GENISLIGI'(1);
            end
            if (baslat_aktif) begin
                baslat_yapildi_d = 1'b1;
            end
            if (yakala) begin
                sonuc_d       = sonuc_sec;
                hedef_cikis_d = hedef_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            birim_q          <= BIRIM_AMB;
            hedef_q          <= '0;
            sayac_q          <= '0;
            baslat_yapildi_q <= 1'b0;
            sonuc_q          <= '0;
            hedef_cikis_q    <= '0;
            zaman_asimi_q    <= 1'b0;
        end else begin
            birim_q          <= birim_d;
            hedef_q          <= hedef_d;
            sayac_q          <= sayac_d;
            baslat_yapildi_q <= baslat_yapildi_d;
            sonuc_q          <= sonuc_d;
            hedef_cikis_q    <= hedef_cikis_d;
            zaman_asimi_q    <= zaman_asimi_d;
        end
    end

endmodule
